// File: rtl/mil1553_pkg.sv
// Shared types and default timing for the dual-redundant 1553 receive-path bus selector.
package mil1553_pkg;

    typedef enum logic {
        BUS_A = 1'b0,
        BUS_B = 1'b1
    } bus_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TX    = 2'd3
    } bus_sel_state_e;

    localparam int DEF_GAP_CYCLES    = 40;
    localparam int DEF_ACT_EDGES     = 3;
    localparam int DEF_IDLE_CYCLES   = 160;
    localparam int DEF_ALLOW_PREEMPT = 1;

    function automatic bus_e other_bus(input bus_e b);
        return (b == BUS_A) ? BUS_B : BUS_A;
    endfunction

endpackage

// File: rtl/mil1553_bus_selector_activity.sv
// Per-bus activity detector: counts closely spaced line transitions and pulses
// qualify on the edge that completes a run of ACT_EDGES.
module bus_activity_detector
    import mil1553_pkg::*;
#(
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int ACT_EDGES  = DEF_ACT_EDGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pos,
    input  logic i_neg,
    input  logic i_clr,
    output logic o_edge,
    output logic o_qualify
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int EW = $clog2(ACT_EDGES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
    localparam logic [EW-1:0] ACT_MAX = EW'(ACT_EDGES);
    localparam logic [EW-1:0] ONE_EDGE = EW'(1);

    logic          pos_q, neg_q;
    logic [GW-1:0] gap_q, gap_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic          expired;

    always_comb begin
        o_edge  = (i_pos != pos_q) || (i_neg != neg_q);
        expired = (gap_q == GAP_MAX);

        gap_d = gap_q;
        if (o_edge) begin
            gap_d = '0;
        end else if (!expired) begin
            gap_d = gap_q + 1'b1;
        end

        // An edge arriving after the gap expired starts a fresh run rather than extending the old one.
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (o_edge) begin
            if (expired) begin
                cnt_d = ONE_EDGE;
            end else if (cnt_q != ACT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (expired) begin
            cnt_d = '0;
        end

        o_qualify = !i_clr && o_edge && (cnt_d == ACT_MAX) && (cnt_q != ACT_MAX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_q <= 1'b0;
            neg_q <= 1'b0;
            gap_q <= '0;
            cnt_q <= '0;
        end else begin
            pos_q <= i_pos;
            neg_q <= i_neg;
            gap_q <= gap_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mil1553_bus_selector.sv
// Decides which 1553 bus owns the shared Manchester decoder and grants the
// local transmitter onto one bus; all outputs come straight from flops.
module mil1553_bus_selector
    import mil1553_pkg::*;
#(
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int ACT_EDGES     = DEF_ACT_EDGES,
    parameter int IDLE_CYCLES   = DEF_IDLE_CYCLES,
    parameter int ALLOW_PREEMPT = DEF_ALLOW_PREEMPT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bus_a_pos,
    input  logic i_bus_a_neg,
    input  logic i_bus_b_pos,
    input  logic i_bus_b_neg,
    input  logic i_tx_req,
    input  logic i_tx_bus,
    output logic o_rx_pos,
    output logic o_rx_neg,
    output logic o_sel_valid,
    output logic o_sel_bus,
    output logic o_tx_gnt,
    output logic o_tx_inh_a,
    output logic o_tx_inh_b,
    output logic o_preempt
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    bus_sel_state_e state_q, state_d;
    bus_e           rr_q, rr_d;
    bus_e           sel_bus_q, sel_bus_d;
    bus_e           own_bus;
    logic [IW-1:0]  idle_q, idle_d, idle_inc;
    logic           rx_pos_q, rx_pos_d, rx_neg_q, rx_neg_d;
    logic           sel_valid_q, sel_valid_d, tx_gnt_q, tx_gnt_d;
    logic           inh_a_q, inh_a_d, inh_b_q, inh_b_d, preempt_q, preempt_d;
    logic           edge_a, edge_b, qual_a, qual_b, clr_a, clr_b;
    logic           owning, own_edge, alt_qual, timeout;

    assign owning   = (state_q == OWN_A) || (state_q == OWN_B);
    assign own_bus  = (state_q == OWN_B) ? BUS_B : BUS_A;
    assign own_edge = (state_q == OWN_B) ? edge_b : edge_a;
    assign alt_qual = (state_q == OWN_B) ? qual_a : qual_b;
    assign idle_inc = idle_q + 1'b1;
    assign timeout  = owning && !own_edge && (idle_inc == IDLE_MAX);

    // Counters are held clear while transmitting so our own echo cannot claim a bus.
    assign clr_a = (state_q == TX) || (timeout && (state_q == OWN_A));
    assign clr_b = (state_q == TX) || (timeout && (state_q == OWN_B));

    bus_activity_detector #(.GAP_CYCLES(GAP_CYCLES), .ACT_EDGES(ACT_EDGES)) u_act_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_pos(i_bus_a_pos), .i_neg(i_bus_a_neg),
        .i_clr(clr_a), .o_edge(edge_a), .o_qualify(qual_a)
    );

    bus_activity_detector #(.GAP_CYCLES(GAP_CYCLES), .ACT_EDGES(ACT_EDGES)) u_act_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_pos(i_bus_b_pos), .i_neg(i_bus_b_neg),
        .i_clr(clr_b), .o_edge(edge_b), .o_qualify(qual_b)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        sel_bus_d = sel_bus_q;
        idle_d    = '0;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_tx_req) begin
                    state_d   = TX;
                    sel_bus_d = bus_e'(i_tx_bus);
                end else if (qual_a && qual_b) begin
                    state_d   = (rr_q == BUS_A) ? OWN_A : OWN_B;
                    sel_bus_d = rr_q;
                    rr_d      = other_bus(rr_q);
                end else if (qual_a) begin
                    state_d   = OWN_A;
                    sel_bus_d = BUS_A;
                end else if (qual_b) begin
                    state_d   = OWN_B;
                    sel_bus_d = BUS_B;
                end
            end
            OWN_A, OWN_B: begin
                idle_d = own_edge ? '0 : idle_inc;
                // A pending transmit request for the other bus blocks preemption but not idle release.
                if (i_tx_req && (i_tx_bus == own_bus)) begin
                    state_d = TX;
                    idle_d  = '0;
                end else if (alt_qual && (ALLOW_PREEMPT != 0) && !i_tx_req) begin
                    state_d   = (own_bus == BUS_A) ? OWN_B : OWN_A;
                    sel_bus_d = other_bus(own_bus);
                    preempt_d = 1'b1;
                    idle_d    = '0;
                end else if (timeout) begin
                    state_d = IDLE;
                    idle_d  = '0;
                end
            end
            TX: begin
                if (!i_tx_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sel_valid_d = (state_d == OWN_A) || (state_d == OWN_B);
        rx_pos_d    = (state_d == OWN_A) ? i_bus_a_pos : ((state_d == OWN_B) ? i_bus_b_pos : 1'b0);
        rx_neg_d    = (state_d == OWN_A) ? i_bus_a_neg : ((state_d == OWN_B) ? i_bus_b_neg : 1'b0);
        tx_gnt_d    = (state_d == TX);
        inh_a_d     = !((state_d == TX) && (sel_bus_d == BUS_A));
        inh_b_d     = !((state_d == TX) && (sel_bus_d == BUS_B));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rr_q        <= BUS_A;
            sel_bus_q   <= BUS_A;
            idle_q      <= '0;
            rx_pos_q    <= 1'b0;
            rx_neg_q    <= 1'b0;
            sel_valid_q <= 1'b0;
            tx_gnt_q    <= 1'b0;
            inh_a_q     <= 1'b1;
            inh_b_q     <= 1'b1;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            sel_bus_q   <= sel_bus_d;
            idle_q      <= idle_d;
            rx_pos_q    <= rx_pos_d;
            rx_neg_q    <= rx_neg_d;
            sel_valid_q <= sel_valid_d;
            tx_gnt_q    <= tx_gnt_d;
            inh_a_q     <= inh_a_d;
            inh_b_q     <= inh_b_d;
            preempt_q   <= preempt_d;
        end
    end

    assign o_rx_pos    = rx_pos_q;
    assign o_rx_neg    = rx_neg_q;
    assign o_sel_valid = sel_valid_q;
    assign o_sel_bus   = sel_bus_q;
    assign o_tx_gnt    = tx_gnt_q;
    assign o_tx_inh_a  = inh_a_q;
    assign o_tx_inh_b  = inh_b_q;
    assign o_preempt   = preempt_q;

endmodule
